// File: rtl/sn74ls_norn_reg.sv
// Clocked multi-channel NOR zero-detector with registered, debounced and sticky modes.
// Propagation delays come from back-annotated timing data; this RTL is zero-delay.
module sn74ls_norn_reg #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int HOLD     = 3,
  parameter int CW       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic                      ack,
  input  logic [CHANNELS*WIDTH-1:0] a,
  output logic [CHANNELS-1:0]       y,
  output logic                      evt
);

  localparam logic [1:0]  MODE_REG   = 2'b00;
  localparam logic [1:0]  MODE_DEB   = 2'b01;
  localparam logic [1:0]  MODE_STICK = 2'b10;
  localparam logic [CW-1:0] HOLD_C   = CW'(HOLD);
  localparam logic [CW:0]   HOLD_W   = (CW+1)'(HOLD);

  logic [CHANNELS-1:0] r_y;
  logic                r_evt;
  logic [1:0]          r_modeQ;
  logic [CW-1:0]       r_cnt [CHANNELS];

  logic [CHANNELS-1:0] w_z;
  logic [CHANNELS-1:0] w_yNext;
  logic [CW-1:0]       w_cntNext [CHANNELS];
  logic [CW:0]         w_inc [CHANNELS];
  logic                w_modeChange;

  assign w_modeChange = (mode != r_modeQ);

  // Extra counter bit keeps the increment from wrapping when HOLD sits at the top of the range.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_z[c]       = ~|a[c*WIDTH +: WIDTH];
      w_inc[c]     = {1'b0, r_cnt[c]} + 1'b1;
      w_yNext[c]   = r_y[c];
      w_cntNext[c] = '0;
      case (r_modeQ)
        MODE_DEB: begin
          if (w_z[c]) begin
            if (w_inc[c] >= HOLD_W) begin
              w_cntNext[c] = HOLD_C;
              w_yNext[c]   = 1'b1;
            end else begin
              w_cntNext[c] = w_inc[c][CW-1:0];
            end
          end else begin
            w_yNext[c] = 1'b0;
          end
        end
        MODE_STICK: begin
          if (w_z[c]) begin
            w_yNext[c] = 1'b1;
          end else if (ack) begin
            w_yNext[c] = 1'b0;
          end
        end
        default: begin
          w_yNext[c] = w_z[c];
        end
      endcase
    end
  end

  // A mode change spends its edge clearing state so the new mode starts from a clean slate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y     <= '0;
      r_evt   <= 1'b0;
      r_modeQ <= MODE_REG;
      for (int c = 0; c < CHANNELS; c++) begin
        r_cnt[c] <= '0;
      end
    end else if (en) begin
      if (w_modeChange) begin
        r_modeQ <= mode;
        r_y     <= '0;
        r_evt   <= 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
          r_cnt[c] <= '0;
        end
      end else begin
        r_y   <= w_yNext;
        r_evt <= |(w_yNext & ~r_y);
        for (int c = 0; c < CHANNELS; c++) begin
          r_cnt[c] <= w_cntNext[c];
        end
      end
    end else begin
      r_evt <= 1'b0;
    end
  end

  assign y   = r_y;
  assign evt = r_evt;

endmodule

// File: tb/tb_sn74ls_norn_reg.sv
// Scoreboard bench for sn74ls_norn_reg: a behavioural model queues expected y/evt per edge.
module tb_sn74ls_norn_reg;

  localparam int W = 5;
  localparam int C = 4;
  localparam int H = 3;
  localparam int N = C * W;

  localparam logic [N-1:0] ALLHI = 20'h08421;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         ack;
  logic [N-1:0] a;
  logic [C-1:0] y;
  logic         evt;

  typedef struct {
    logic [C-1:0] y;
    logic         evt;
  } expT;

  expT sb[$];

  int checks = 0;
  int errors = 0;

  logic [C-1:0] mY    = '0;
  logic         mEvt  = 1'b0;
  logic [1:0]   mMode = 2'b00;
  int           mCnt [C];

  sn74ls_norn_reg #(
    .WIDTH(W), .CHANNELS(C), .HOLD(H), .CW(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ack(ack),
    .a(a), .y(y), .evt(evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    mY    = '0;
    mEvt  = 1'b0;
    mMode = 2'b00;
    for (int i = 0; i < C; i++) mCnt[i] = 0;
  endtask

  task automatic modelStep(input logic e, input logic [1:0] m, input logic k, input logic [N-1:0] av);
    logic [C-1:0] ny;
    logic         zz;
    if (!e) begin
      mEvt = 1'b0;
    end else if (m != mMode) begin
      mMode = m;
      mY    = '0;
      mEvt  = 1'b0;
      for (int i = 0; i < C; i++) mCnt[i] = 0;
    end else begin
      ny = mY;
      for (int i = 0; i < C; i++) begin
        zz = (av[i*W +: W] == '0);
        if (mMode == 2'b01) begin
          if (zz) begin
            if (mCnt[i] + 1 >= H) ny[i] = 1'b1;
            mCnt[i] = (mCnt[i] + 1 > H) ? H : mCnt[i] + 1;
          end else begin
            mCnt[i] = 0;
            ny[i]   = 1'b0;
          end
        end else if (mMode == 2'b10) begin
          mCnt[i] = 0;
          if (zz) ny[i] = 1'b1;
          else if (k) ny[i] = 1'b0;
        end else begin
          mCnt[i] = 0;
          ny[i]   = zz;
        end
      end
      mEvt = |(ny & ~mY);
      mY   = ny;
    end
  endtask

  // Called just after an edge: drives inputs, queues the model's prediction, checks after the next edge.
  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic k,
                               input logic [N-1:0] av, input string tag);
    expT ex;
    en   = e;
    mode = m;
    ack  = k;
    a    = av;
    modelStep(e, m, k, av);
    ex.y   = mY;
    ex.evt = mEvt;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      ex = sb.pop_front();
      checkOutput({tag, "_y"}, 32'(y), 32'(ex.y));
      checkOutput({tag, "_evt"}, 32'(evt), 32'(ex.evt));
    end
  endtask

  initial begin
    logic [1:0]   rm;
    logic [N-1:0] ra;
    modelReset();
    rst  = 1'b1;
    en   = 1'b1;
    mode = 2'b00;
    ack  = 1'b0;
    a    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_evt", 32'(evt), 32'd0);
    rst = 1'b0;

    applyStimulus(1, 2'b00, 0, '0, "rel");
    checkOutput("rel_const_y", 32'(y), 32'hF);
    checkOutput("rel_const_evt", 32'(evt), 32'd1);
    applyStimulus(1, 2'b00, 0, '0, "rel2");
    checkOutput("rel2_const_evt", 32'(evt), 32'd0);

    applyStimulus(1, 2'b00, 0, 20'h02000, "m00_ch2");
    checkOutput("m00_ch2_const", 32'(y), 32'hB);
    applyStimulus(1, 2'b00, 0, '0, "m00_clr");
    applyStimulus(1, 2'b00, 0, '0, "m00_idle");
    applyStimulus(1, 2'b11, 0, 20'h00400, "m11_sw");
    applyStimulus(1, 2'b11, 0, 20'h00400, "m11_ch2");

    applyStimulus(1, 2'b01, 0, ALLHI, "m01_sw");
    applyStimulus(1, 2'b01, 0, 20'h08420, "m01_e1");
    applyStimulus(1, 2'b01, 0, 20'h08420, "m01_e2");
    checkOutput("m01_e2_const", 32'(y), 32'd0);
    applyStimulus(1, 2'b01, 0, 20'h08420, "m01_e3");
    checkOutput("m01_e3_const", 32'(y), 32'h1);
    applyStimulus(1, 2'b01, 0, ALLHI, "m01_drop");
    applyStimulus(1, 2'b01, 0, 20'h08420, "m01_g1");
    applyStimulus(1, 2'b01, 0, ALLHI, "m01_glitch");
    applyStimulus(1, 2'b01, 0, 20'h08420, "m01_r1");
    applyStimulus(1, 2'b01, 0, 20'h08420, "m01_r2");
    applyStimulus(1, 2'b01, 0, 20'h08420, "m01_r3");
    checkOutput("m01_r3_const", 32'(y), 32'h1);

    applyStimulus(1, 2'b10, 0, ALLHI, "m10_sw");
    applyStimulus(1, 2'b10, 0, 20'h08401, "m10_set");
    applyStimulus(1, 2'b10, 0, ALLHI, "m10_hold");
    checkOutput("m10_hold_const", 32'(y), 32'h2);
    applyStimulus(1, 2'b10, 1, ALLHI, "m10_ack");
    checkOutput("m10_ack_const", 32'(y), 32'h0);
    applyStimulus(1, 2'b10, 0, 20'h08401, "m10_set2");
    applyStimulus(1, 2'b10, 1, 20'h08401, "m10_ackset");
    checkOutput("m10_ackset_const", 32'(y), 32'h2);
    applyStimulus(1, 2'b10, 0, ALLHI, "m10_keep");

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 2'b10, 1'($urandom_range(0, 1)), N'($urandom), "en0");
    end
    checkOutput("en0_const", 32'(y), 32'h2);
    applyStimulus(1, 2'b00, 0, '0, "sw10_00");
    checkOutput("sw10_00_const", 32'(y), 32'h0);

    applyStimulus(1, 2'b01, 0, ALLHI, "ar_sw");
    applyStimulus(1, 2'b01, 0, 20'h08401, "ar_e1");
    applyStimulus(1, 2'b01, 0, 20'h08400, "ar_e2");
    applyStimulus(1, 2'b01, 0, 20'h08400, "ar_e3");
    checkOutput("ar_pre_const", 32'(y), 32'h2);
    #3 rst = 1'b1;
    #1;
    checkOutput("ar_async_y", 32'(y), 32'd0);
    checkOutput("ar_async_evt", 32'(evt), 32'd0);
    modelReset();
    #1 rst = 1'b0;
    applyStimulus(1, 2'b01, 0, 20'h08400, "ar_sw2");
    applyStimulus(1, 2'b01, 0, 20'h08400, "ar_c1");
    applyStimulus(1, 2'b01, 0, 20'h08400, "ar_c2");
    checkOutput("ar_c2_const", 32'(y), 32'h0);
    applyStimulus(1, 2'b01, 0, 20'h08400, "ar_c3");
    checkOutput("ar_c3_const", 32'(y), 32'h3);

    rm = 2'b01;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) rm = 2'($urandom_range(0, 3));
      for (int c = 0; c < C; c++) begin
        ra[c*W +: W] = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom);
      end
      applyStimulus(1'($urandom_range(0, 7) != 0), rm, 1'($urandom_range(0, 1)), ra, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
